matmul_addr_ctrl: RTL and testbench

//  Sequencer for the dual-port address-register datapath (AddrReg_DP) in the matrix-multiply engine.
//  On a start pulse it restarts the address datapath and holds its Load high for exactly N^3/2 cycles.
//  It tracks the A/B memory read latency to drive the MAC clear/enable strobes.
//  It writes each finished C element to the result memory in row-major order (C[i][j] at i*N+j).

---
 rtl/matmul_pkg.sv | 31 +++
 rtl/matmul_tag_pipe.sv | 30 +++
 rtl/matmul_addr_ctrl.sv | 124 ++++++++++++
 tb/tb_matmul_addr_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply address sequencer.
// Holds the FSM encoding, default sizing, a clog2 helper and the beat tag.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DRAIN,
    DONE
  } ctrlState_t;

  localparam int DefN     = 8;
  localparam int DefAw    = 8;
  localparam int DefRdLat = 1;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beatTag_t;

  // Never returns less than 1 so counters stay at least one bit wide.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/matmul_tag_pipe.sv
// Delays beat tags by the A/B memory read latency.
// Ports: clk, reset (async), flush (sync clear), tagIn, tagOut.
module matmul_tag_pipe
  import matmul_pkg::*;
#(
  parameter int Depth = DefRdLat
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  beatTag_t tagIn,
  output beatTag_t tagOut
);

  beatTag_t stage [Depth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < Depth; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tagIn;
      for (int i = 1; i < Depth; i++) stage[i] <= stage[i-1];
    end
  end

  assign tagOut = stage[Depth-1];

endmodule

// File: rtl/matmul_addr_ctrl.sv
// Sequencer for AddrReg_DP, MAC strobes and row-major C memory writes.
// Ports: clk, reset, start, abort -> busy, done, addr_rst, addr_load,
//        mac_clr, mac_en, c_we, c_addr.
module matmul_addr_ctrl
  import matmul_pkg::*;
#(
  parameter int N      = DefN,
  parameter int AW     = DefAw,
  parameter int RD_LAT = DefRdLat
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          addr_rst,
  output logic          addr_load,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          c_we,
  output logic [AW-1:0] c_addr
);

  localparam int Half = N / 2;
  localparam int KW   = clog2(Half);
  localparam int EW   = clog2(N * N);

  localparam logic [KW-1:0] KLast = KW'(Half - 1);
  localparam logic [EW-1:0] ELast = EW'(N * N - 1);
  localparam logic [AW-1:0] CLast = AW'(N * N - 1);

  ctrlState_t    state;
  ctrlState_t    nextState;
  logic [KW-1:0] k;
  logic [EW-1:0] elem;
  logic          cWeQ;
  logic [AW-1:0] cAddrQ;
  logic          flush;
  logic          lastBeat;
  logic          lastWrite;
  beatTag_t      tagIn;
  beatTag_t      tagOut;

  assign flush     = abort && (state != IDLE);
  assign lastBeat  = (k == KLast) && (elem == ELast);
  assign lastWrite = cWeQ && (cAddrQ == CLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start && !abort) nextState = INIT;
      INIT:    nextState = RUN;
      RUN:     if (lastBeat) nextState = DRAIN;
      DRAIN:   if (lastWrite) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (flush) nextState = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k    <= '0;
      elem <= '0;
    end else if (state == INIT) begin
      k    <= '0;
      elem <= '0;
    end else if (state == RUN) begin
      if (k == KLast) begin
        k    <= '0;
        elem <= elem + 1'b1;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  always_comb begin
    tagIn       = '0;
    tagIn.valid = (state == RUN);
    tagIn.first = (state == RUN) && (k == '0);
    tagIn.last  = (state == RUN) && (k == KLast);
  end

  matmul_tag_pipe #(
    .Depth (RD_LAT)
  ) uTagPipe (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .tagIn  (tagIn),
    .tagOut (tagOut)
  );

  // The MAC result is ready the cycle after the element's last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cWeQ   <= 1'b0;
      cAddrQ <= '0;
    end else if (flush) begin
      cWeQ <= 1'b0;
    end else begin
      cWeQ <= tagOut.valid && tagOut.last;
      if (state == INIT) cAddrQ <= '0;
      else if (cWeQ)     cAddrQ <= cAddrQ + 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign addr_rst  = (state == INIT);
  assign addr_load = (state == RUN);
  assign mac_en    = tagOut.valid;
  assign mac_clr   = tagOut.valid && tagOut.first;
  assign c_we      = cWeQ;
  assign c_addr    = cAddrQ;

endmodule

// File: tb/tb_matmul_addr_ctrl.sv
// Bench for matmul_addr_ctrl: RD_LAT=1 and RD_LAT=3 instances in lockstep.
// Timeline model per run plus a memory/MAC model checked against golden A*B.
module tb_matmul_addr_ctrl;

  localparam int N     = 8;
  localparam int KN    = N / 2;
  localparam int HALF3 = N * N * N / 2;
  localparam int NE    = N * N;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic abort;

  logic [1:0]      busy;
  logic [1:0]      done;
  logic [1:0]      addrRst;
  logic [1:0]      addrLoad;
  logic [1:0]      macClr;
  logic [1:0]      macEn;
  logic [1:0]      cWe;
  logic [1:0][7:0] cAddr;

  always #5 clk = ~clk;

  matmul_addr_ctrl #(.N(N), .AW(8), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy[0]), .done(done[0]), .addr_rst(addrRst[0]),
    .addr_load(addrLoad[0]), .mac_clr(macClr[0]), .mac_en(macEn[0]),
    .c_we(cWe[0]), .c_addr(cAddr[0])
  );

  matmul_addr_ctrl #(.N(N), .AW(8), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy[1]), .done(done[1]), .addr_rst(addrRst[1]),
    .addr_load(addrLoad[1]), .mac_clr(macClr[1]), .mac_en(macEn[1]),
    .c_we(cWe[1]), .c_addr(cAddr[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit act [2];
  int rs [2];

  int writes [2];
  int dones [2];
  int loads [2];
  int firstWe [2];
  int doneRel [2];
  int beat [2];
  longint acc [2];
  longint cMem [2][NE];
  longint dataAt [longint];

  int matA [N][N];
  int matB [N][N];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Expected {busy,done,addr_rst,addr_load,mac_clr,mac_en,c_we} for a
  // cycle rel cycles after the start-sampling edge.
  function automatic logic [6:0] expOut(input int l, input int rel,
                                         input bit a);
    logic [6:0] r;
    bit en;
    r = '0;
    if (!a || rel < 1 || rel > HALF3 + 3 + l) return r;
    en   = (rel >= 2 + l) && (rel <= HALF3 + 1 + l);
    r[6] = 1'b1;
    r[5] = (rel == HALF3 + 3 + l);
    r[4] = (rel == 1);
    r[3] = (rel >= 2) && (rel <= HALF3 + 1);
    r[2] = en && ((rel - 2 - l) % KN == 0);
    r[1] = en;
    r[0] = (rel >= KN + 2 + l) && (rel <= HALF3 + 2 + l)
           && ((rel - KN - 2 - l) % KN == 0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Model process: decides which start/abort/reset the DUT must honour.
  initial begin
    act[0] = 1'b0;
    act[1] = 1'b0;
    rs[0]  = 0;
    rs[1]  = 0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        bit idle;
        idle = !act[i] || (cyc - rs[i] > HALF3 + 3 + lat(i));
        if (reset) begin
          act[i] = 1'b0;
        end else if (!idle && abort) begin
          act[i] = 1'b0;
        end else if (idle && start && !abort) begin
          act[i] = 1'b1;
          rs[i]  = cyc;
        end
      end
      cyc = cyc + 1;
    end
  end

  // Compare process plus the A/B memory and MAC environment.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int l;
        int rel;
        int bi;
        int ei;
        int kk;
        longint p;
        logic [6:0] e;
        logic [6:0] a;
        l   = lat(i);
        rel = cyc - rs[i];
        e   = reset ? 7'd0 : expOut(l, rel, act[i]);
        a   = {busy[i], done[i], addrRst[i], addrLoad[i],
               macClr[i], macEn[i], cWe[i]};
        chk($sformatf("strobes i%0d cyc%0d", i, cyc), 32'(a), 32'(e));
        if (e[0])
          chk($sformatf("c_addr i%0d cyc%0d", i, cyc), 32'(cAddr[i]),
              32'((rel - KN - 2 - l) / KN));
        if (!reset && act[i] && rel == 1) begin
          writes[i]  = 0;
          dones[i]   = 0;
          loads[i]   = 0;
          firstWe[i] = -1;
          doneRel[i] = -1;
          for (int x = 0; x < NE; x++) cMem[i][x] = -1;
        end
        if (cWe[i] === 1'b1) begin
          writes[i]++;
          if (firstWe[i] < 0) firstWe[i] = rel;
          if (cAddr[i] < NE) cMem[i][cAddr[i]] = acc[i];
        end
        if (done[i] === 1'b1) begin
          dones[i]++;
          doneRel[i] = rel;
        end
        if (addrRst[i] === 1'b1) beat[i] = 0;
        if (addrLoad[i] === 1'b1) begin
          loads[i]++;
          bi = beat[i] % (HALF3);
          ei = bi / KN;
          kk = bi % KN;
          p  = matA[ei/N][2*kk] * matB[2*kk][ei%N]
             + matA[ei/N][2*kk+1] * matB[2*kk+1][ei%N];
          dataAt[longint'(cyc + l) * 2 + i] = p;
          beat[i]++;
        end
        if (macEn[i] === 1'b1) begin
          p = 0;
          if (dataAt.exists(longint'(cyc) * 2 + i)) begin
            p = dataAt[longint'(cyc) * 2 + i];
            dataAt.delete(longint'(cyc) * 2 + i);
          end
          acc[i] = (macClr[i] === 1'b1) ? p : acc[i] + p;
        end
      end
    end
  end

  task automatic waitTo(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic fillMats();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        matA[r][c] = int'($urandom_range(0, 255));
        matB[r][c] = int'($urandom_range(0, 255));
      end
  endtask

  task automatic verifyFull(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s loads i%0d", tag, i), 32'(loads[i]), 32'd256);
      chk($sformatf("%s writes i%0d", tag, i), 32'(writes[i]), 32'd64);
      chk($sformatf("%s dones i%0d", tag, i), 32'(dones[i]), 32'd1);
      chk($sformatf("%s firstWe i%0d", tag, i), 32'(firstWe[i]),
          (i == 0) ? 32'd7 : 32'd9);
      chk($sformatf("%s doneRel i%0d", tag, i), 32'(doneRel[i]),
          (i == 0) ? 32'd260 : 32'd262);
      for (int e = 0; e < NE; e++) begin
        longint g;
        g = 0;
        for (int x = 0; x < N; x++) g += matA[e/N][x] * matB[x][e%N];
        chk($sformatf("%s C i%0d e%0d", tag, i, e), 32'(cMem[i][e]),
            32'(g));
      end
    end
    chk({tag, " idle after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    fillMats();
    #100;
    @(posedge clk);
    #2;
    reset = 1'b0;
    waitTo(cyc + 20);
    chk("idle outputs",
        32'({busy, done, addrRst, addrLoad, macClr, macEn, cWe}), 32'd0);
    chk("idle c_addr", 32'(cAddr), 32'd0);

    fillMats();
    s = cyc;
    pulseStart();
    waitTo(s + 275);
    verifyFull("run1");

    fillMats();
    s = cyc;
    pulseStart();
    waitTo(s + 50);
    pulseStart();
    waitTo(s + 260);
    pulseStart();
    waitTo(s + 275);
    verifyFull("spurious");

    fillMats();
    s = cyc;
    pulseStart();
    waitTo(s + 100);
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    waitTo(s + 115);
    chk("abort writes i0", 32'(writes[0]), 32'd24);
    chk("abort writes i1", 32'(writes[1]), 32'd23);
    chk("abort dones i0", 32'(dones[0]), 32'd0);
    chk("abort dones i1", 32'(dones[1]), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);

    fillMats();
    s = cyc;
    pulseStart();
    waitTo(s + 275);
    verifyFull("postAbort");

    fillMats();
    s = cyc;
    pulseStart();
    waitTo(s + 120);
    reset = 1'b1;
    #1;
    chk("reset outputs",
        32'({busy, done, addrRst, addrLoad, macClr, macEn, cWe}), 32'd0);
    chk("reset c_addr", 32'(cAddr), 32'd0);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    reset = 1'b0;
    waitTo(cyc + 3);

    fillMats();
    s = cyc;
    pulseStart();
    waitTo(s + 275);
    verifyFull("postReset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
